// File: rtl/mode_loop.sv
// mode_loop: master/worker run controller.
//
// A master FSM accepts a start request, latches a run length and a round
// count, and launches each round on a worker counter FSM. The worker counts
// 1..L and then signals round exit; after the last round the master pulses
// done. abort cancels a run in progress.
//
// Ports:
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous active-high reset
//   start    in   1      run request, sampled only while idle
//   len      in   CNT_W  counts per round (0 treated as 1), latched on start
//   rounds   in   RND_W  number of rounds (0 treated as 1), latched on start
//   abort    in   1      cancels the current run, sampled only while busy
//   busy     out  1      run in progress
//   done     out  1      one-cycle pulse on normal completion
//   aborted  out  1      one-cycle pulse on abort
//   cnt      out  CNT_W  worker count, 0 while the worker is idle
//   round    out  RND_W  current round index, 0-based
module mode_loop #(
    parameter int CNT_W = 4,
    parameter int RND_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [RND_W-1:0] rounds,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] cnt,
    output logic [RND_W-1:0] round
);

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_RUN  = 2'd1,
        M_LAST = 2'd2
    } m_state_t;

    typedef enum logic {
        W_S0 = 1'b0,
        W_S1 = 1'b1
    } w_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [RND_W-1:0] RND_ONE = RND_W'(1'b1);

    m_state_t         m_state_q, m_state_d;
    w_state_t         w_state_q, w_state_d;
    logic [CNT_W-1:0] len_q, len_d;       // effective L, never 0
    logic [RND_W-1:0] rnds_q, rnds_d;     // effective R, never 0
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RND_W-1:0] round_q, round_d;
    logic             enter_s;
    logic             exit_s;

    // Worker reaches the end of its round once the count has caught up with L.
    assign exit_s = (w_state_q == W_S1) && (cnt_q >= len_q);

    // Next-state logic for both FSMs, with abort applied last so it overrides.
    always_comb begin
        m_state_d = m_state_q;
        w_state_d = w_state_q;
        len_d     = len_q;
        rnds_d    = rnds_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        cnt_d     = cnt_q;
        round_d   = round_q;
        enter_s   = 1'b0;

        case (m_state_q)
            M_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    m_state_d = M_RUN;
                    enter_s   = 1'b1;
                    busy_d    = 1'b1;
                    round_d   = '0;
                    len_d     = (len == '0) ? CNT_ONE : len;
                    rnds_d    = (rounds == '0) ? RND_ONE : rounds;
                end else begin
                    m_state_d = M_IDLE;
                end
            end
            M_RUN: begin
                if (exit_s) begin
                    if (round_q < (rnds_q - RND_ONE)) begin
                        enter_s = 1'b1;
                        round_d = round_q + RND_ONE;
                    end else begin
                        m_state_d = M_LAST;
                        done_d    = 1'b1;
                    end
                end else begin
                    m_state_d = M_RUN;
                end
            end
            M_LAST: begin
                m_state_d = M_IDLE;
                busy_d    = 1'b0;
            end
            default: begin
                m_state_d = M_IDLE;
                busy_d    = 1'b0;
                round_d   = '0;
            end
        endcase

        case (w_state_q)
            W_S0: begin
                cnt_d = '0;
                if (enter_s) begin
                    w_state_d = W_S1;
                end else begin
                    w_state_d = W_S0;
                end
            end
            W_S1: begin
                if (exit_s) begin
                    // A back-to-back round re-enters directly, leaving one
                    // cycle of cnt=0 between rounds.
                    cnt_d     = '0;
                    w_state_d = enter_s ? W_S1 : W_S0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                w_state_d = W_S0;
                cnt_d     = '0;
            end
        endcase

        // Illegal master encodings also park the worker.
        if ((m_state_q != M_IDLE) && (m_state_q != M_RUN) && (m_state_q != M_LAST)) begin
            w_state_d = W_S0;
            cnt_d     = '0;
        end else begin
            w_state_d = w_state_d;
        end

        if (busy_q && abort) begin
            m_state_d = M_IDLE;
            w_state_d = W_S0;
            cnt_d     = '0;
            busy_d    = 1'b0;
            round_d   = '0;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end else begin
            aborted_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state_q <= M_IDLE;
            w_state_q <= W_S0;
            len_q     <= CNT_ONE;
            rnds_q    <= RND_ONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cnt_q     <= '0;
            round_q   <= '0;
        end else begin
            m_state_q <= m_state_d;
            w_state_q <= w_state_d;
            len_q     <= len_d;
            rnds_q    <= rnds_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            cnt_q     <= cnt_d;
            round_q   <= round_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign cnt     = cnt_q;
    assign round   = round_q;

endmodule
